// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single data-memory port: CPU (A) normally wins, B gets a
// starvation-forced slot or an exclusive lock. Optional stats counters: DMEM_ARB_STATS_EN.
module dmem_arbiter #(
    parameter int ADDR_W     = 6,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [1:0]        a_sel,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [31:0]       a_wdata,
    output logic              a_ready,
    output logic              a_stall,
    output logic [31:0]       a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [1:0]        b_sel,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [31:0]       b_wdata,
    output logic              b_ready,
    output logic [31:0]       b_rdata,
    input  logic              b_lock,
    output logic              dm_cs,
    output logic              dm_r,
    output logic              dm_w,
    output logic [1:0]        dm_sel,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    input  logic [31:0]       dm_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]       conflict_cnt,
    output logic [15:0]       a_stall_cnt
`endif
);

    typedef enum logic {ARB, LOCK_B} state_t;

    localparam logic [3:0] LIM = 4'(STARVE_LIM);

    state_t     state, state_nxt;
    logic [3:0] starve_cnt, starve_nxt;
    logic       grant_a, grant_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    always_comb begin
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        state_nxt = state;
        if (!rst) begin
            case (state)
                ARB: begin
                    grant_a = a_req && !(b_req && (starve_cnt >= LIM));
                    grant_b = b_req && !grant_a;
                    if (grant_b && b_lock)
                        state_nxt = LOCK_B;
                end
                LOCK_B: begin
                    // exclusive to B even on the cycle b_lock drops
                    grant_b = b_req;
                    if (!b_lock)
                        state_nxt = ARB;
                end
                default: state_nxt = ARB;
            endcase
        end
    end

    always_comb begin
        if (b_req && !grant_b)
            starve_nxt = (starve_cnt == 4'hF) ? starve_cnt : starve_cnt + 4'd1;
        else
            starve_nxt = '0;
    end

    always_comb begin
        dm_cs    = 1'b0;
        dm_r     = 1'b0;
        dm_w     = 1'b0;
        dm_sel   = '0;
        dm_addr  = '0;
        dm_wdata = '0;
        if (grant_a) begin
            dm_cs    = 1'b1;
            dm_w     = a_we;
            dm_r     = !a_we;
            dm_sel   = a_sel;
            dm_addr  = a_addr;
            dm_wdata = a_wdata;
        end else if (grant_b) begin
            dm_cs    = 1'b1;
            dm_w     = b_we;
            dm_r     = !b_we;
            dm_sel   = b_sel;
            dm_addr  = b_addr;
            dm_wdata = b_wdata;
        end
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;
    assign a_stall = a_req && !grant_a;
    assign a_rdata = grant_a ? dm_rdata : '0;
    assign b_rdata = grant_b ? dm_rdata : '0;

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
            a_stall_cnt  <= '0;
        end else begin
            if (a_req && b_req)
                conflict_cnt <= conflict_cnt + 16'd1;
            if (a_stall)
                a_stall_cnt <= a_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter: the driver predicts each cycle from a
// behavioural model, the monitor compares on the falling edge.
module tb_dmem_arbiter;
    localparam int AW  = 6;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_req = 0, a_we = 0, b_req = 0, b_we = 0, b_lock = 0;
    logic [1:0]    a_sel = 0, b_sel = 0;
    logic [AW-1:0] a_addr = 0, b_addr = 0;
    logic [31:0]   a_wdata = 0, b_wdata = 0;
    logic          a_ready, a_stall, b_ready, dm_cs, dm_r, dm_w;
    logic [31:0]   a_rdata, b_rdata, dm_wdata, dm_rdata;
    logic [1:0]    dm_sel;
    logic [AW-1:0] dm_addr;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0]   conflict_cnt, a_stall_cnt;
`endif

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .STARVE_LIM(LIM)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_sel(a_sel), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ready(a_ready), .a_stall(a_stall), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_sel(b_sel), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ready(b_ready), .b_rdata(b_rdata), .b_lock(b_lock),
        .dm_cs(dm_cs), .dm_r(dm_r), .dm_w(dm_w), .dm_sel(dm_sel), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
`ifdef DMEM_ARB_STATS_EN
        , .conflict_cnt(conflict_cnt), .a_stall_cnt(a_stall_cnt)
`endif
    );

    // DMEM stand-in: combinational read, write on the edge, known contents after reset
    logic [31:0] mem [64];
    assign dm_rdata = mem[dm_addr];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + i;
        end else if (dm_cs && dm_w) begin
            mem[dm_addr] <= dm_wdata;
        end
    end

    typedef struct {
        logic ar, br, st, cs, r, w;
        logic [1:0] sel;
        logic [AW-1:0] addr;
        logic [31:0] wd, ard, brd;
        int conf, ast;
        bit sv;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    // reference model state
    bit          m_lock = 0;
    int          m_wait = 0;
    logic [31:0] mmem [64];
    int          m_conf = 0, m_ast = 0;
    bit          m_sv = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, ar, awe, input logic [1:0] asl, input logic [AW-1:0] aad,
                        input logic [31:0] awd, input logic brq, bwe, input logic [1:0] bsl,
                        input logic [AW-1:0] bad, input logic [31:0] bwd, input logic bl);
        exp_t e;
        bit ga, gb;
        @(posedge clk);
        #1;
        rst = r; a_req = ar; a_we = awe; a_sel = asl; a_addr = aad; a_wdata = awd;
        b_req = brq; b_we = bwe; b_sel = bsl; b_addr = bad; b_wdata = bwd; b_lock = bl;
        ga = 0; gb = 0;
        if (!r) begin
            if (m_lock) gb = brq;
            else begin
                ga = ar && !(brq && m_wait >= LIM);
                gb = brq && !ga;
            end
        end
        e.ar = ga; e.br = gb; e.st = ar && !ga;
        e.cs = 0; e.r = 0; e.w = 0; e.sel = 0; e.addr = 0; e.wd = 0; e.ard = 0; e.brd = 0;
        if (ga) begin
            e.cs = 1; e.w = awe; e.r = !awe; e.sel = asl; e.addr = aad; e.wd = awd;
            e.ard = mmem[aad];
            if (awe) mmem[aad] = awd;
        end else if (gb) begin
            e.cs = 1; e.w = bwe; e.r = !bwe; e.sel = bsl; e.addr = bad; e.wd = bwd;
            e.brd = mmem[bad];
            if (bwe) mmem[bad] = bwd;
        end
        e.conf = m_conf; e.ast = m_ast; e.sv = m_sv;
        if (r) begin
            for (int i = 0; i < 64; i++) mmem[i] = 32'h1000_0000 + i;
            m_conf = 0; m_ast = 0; m_sv = 1; m_lock = 0; m_wait = 0;
        end else begin
            if (ar && brq) m_conf = (m_conf + 1) % 65536;
            if (e.st) m_ast = (m_ast + 1) % 65536;
            m_lock = m_lock ? bl : (gb && bl);
            m_wait = (brq && !gb) ? m_wait + 1 : 0;
        end
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("a_ready", a_ready, e.ar);
            chk("b_ready", b_ready, e.br);
            chk("a_stall", a_stall, e.st);
            chk("dm_cs", dm_cs, e.cs);
            chk("dm_r", dm_r, e.r);
            chk("dm_w", dm_w, e.w);
            chk("dm_sel", dm_sel, e.sel);
            chk("dm_addr", dm_addr, e.addr);
            chk("dm_wdata", dm_wdata, e.wd);
            chk("a_rdata", a_rdata, e.ard);
            chk("b_rdata", b_rdata, e.brd);
`ifdef DMEM_ARB_STATS_EN
            if (e.sv) begin
                chk("conflict_cnt", conflict_cnt, e.conf[15:0]);
                chk("a_stall_cnt", a_stall_cnt, e.ast[15:0]);
            end
`endif
        end
    end

    initial begin
        // reset with A requesting: stall mirrors a_req
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 2, 3, 32'h1, 1, 1, 1, 4, 32'h2, 1);
        // A only: write then read addr 5
        step(0, 1, 1, 2, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 2, 5, 0, 0, 0, 0, 0, 0, 0);
        // contention for 6 cycles: B forced on the 5th
        for (int i = 0; i < 6; i++)
            step(0, 1, 0, 2, 7, 0, 1, 1, 1, 9, 32'h55 + i, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0);
        // lock: writes to 1,2,3, then lock drop, then A
        step(0, 0, 0, 0, 0, 0, 1, 1, 2, 1, 32'hA1, 1);
        step(0, 1, 0, 2, 1, 0, 1, 1, 2, 2, 32'hA2, 1);
        step(0, 1, 0, 2, 2, 0, 1, 1, 2, 3, 32'hA3, 1);
        step(0, 1, 0, 2, 3, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 2, 3, 0, 0, 0, 0, 0, 0, 0);
        // reset mid-lock
        step(0, 0, 0, 0, 0, 0, 1, 1, 2, 4, 32'hB4, 1);
        step(0, 1, 0, 2, 4, 0, 0, 0, 0, 0, 0, 1);
        step(1, 1, 0, 2, 4, 0, 1, 0, 2, 4, 0, 1);
        step(0, 1, 0, 2, 4, 0, 0, 0, 0, 0, 0, 0);
        // idle
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // random traffic, biased toward contention and short locks
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 70), 1'($urandom), 2'($urandom),
                 AW'($urandom_range(0, 15)), $urandom,
                 ($urandom_range(0, 99) < 60), 1'($urandom), 2'($urandom),
                 AW'($urandom_range(0, 15)), $urandom,
                 ($urandom_range(0, 99) < 20));
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("queue_drain", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port (`DMEM`: CS/R/W/sel/addr/wdata/rdata) between two requesters.
  - Port A: the CPU load/store path.
  - Port B: a debug loader or DMA engine.
- Uncontested requests are granted in the same cycle, so single-cycle CPU timing is preserved.
- On contention the CPU normally wins. A starvation counter and a lock mode give port B guaranteed or atomic access; the CPU is stalled through `a_stall`.
- Sits between the `cpu` memory outputs and `DMEM` inside the top-level dataflow.

Parameters:
- `ADDR_W`, 6: width of the DMEM word/byte address passed through unchanged.
- `STARVE_LIM`, 4: consecutive cycles port B may wait before it is forced ahead of port A (1..15).

Ports:
- `clk` input 1: clock, rising edge.
- `rst` input 1: synchronous reset, active-high.
- `a_req` input 1: CPU access request (`DM_ena`).
- `a_we` input 1: 1 = write, 0 = read.
- `a_sel` input 2: access size code, passed through to DMEM `sel`.
- `a_addr` input `ADDR_W`: CPU address.
- `a_wdata` input 32: CPU write data.
- `a_ready` output 1: CPU access performed this cycle.
- `a_stall` output 1: `a_req & ~a_ready`; freezes the CPU PC and register write.
- `a_rdata` output 32: read data to the CPU.
- `b_req`, `b_we`, `b_sel`, `b_addr`, `b_wdata`, `b_ready`, `b_rdata`: same as the A equivalents, for port B.
- `b_lock` input 1: port B requests exclusive ownership across multiple cycles.
- `dm_cs` output 1: DMEM chip select.
- `dm_r` output 1: DMEM read.
- `dm_w` output 1: DMEM write.
- `dm_sel` output 2: DMEM size select.
- `dm_addr` output `ADDR_W`: DMEM address.
- `dm_wdata` output 32: DMEM write data.
- `dm_rdata` input 32: DMEM combinational read data.

Behaviour:
- **Reset.** While `rst`=1, all grants are suppressed:
  - `a_ready`=`b_ready`=0, `dm_cs`=`dm_r`=`dm_w`=0.
  - `dm_sel`/`dm_addr`/`dm_wdata` = 0.
  - `a_stall` = `a_req`.
  - Registered state clears: FSM=`ARB`, `starve_cnt`=0.
- **Grant timing.** Grant is combinational from the registered state plus current requests.
  - Each granted access completes in the cycle granted. DMEM read is combinational; the write commits at the next rising `clk`.
  - Zero added latency when uncontested.
- **Data muxing.** The granted port's `we`/`sel`/`addr`/`wdata` drive DMEM.
  - `dm_cs`=1, `dm_w`=`we`, `dm_r`=~`we`.
  - No grant: `dm_cs`=0 and the DMEM outputs are 0.
  - `a_rdata` and `b_rdata` both = `dm_rdata` when that port is granted, else 0.
- **FSM state `ARB`:**
  - Grant A if `a_req` and not (`b_req` and `starve_cnt`>=`STARVE_LIM`).
  - Otherwise grant B if `b_req`.
  - If B is granted with `b_lock`=1, next state is `LOCK_B`.
- **FSM state `LOCK_B`:**
  - Only B can be granted; A is always stalled.
  - B stays in the state while `b_lock`=1 (with or without `b_req`; idle lock cycles keep `dm_cs`=0).
  - `b_lock`=0 returns to `ARB` on the next edge. The cycle where `b_lock` first drops is still exclusive to B.
- **`starve_cnt` (4-bit, saturating at 15):**
  - Increments each cycle `b_req`=1 and `b_ready`=0.
  - Clears to 0 on any `b_ready`=1 or when `b_req`=0.
- **Boundary cases:**
  - Simultaneous `a_req`/`b_req` with `starve_cnt`<`STARVE_LIM`: A wins.
  - With `starve_cnt`=`STARVE_LIM`: B wins exactly one cycle, then the counter clears.
  - A write and a read to the same address in consecutive grants: the read returns the new data (DMEM write-before-read on the edge).
  - `rst` asserted in `LOCK_B`: returns to `ARB` and drops the lock; B must re-request.
- **Widths.** Address and data pass through unmodified; there is no arithmetic on the data path. DMEM-base subtraction stays in the top level.

Optional Feature:
- Macro: `DMEM_ARB_STATS_EN`.
- When defined:
  - Adds output `conflict_cnt` [15:0]: increments (wrapping) each cycle `a_req`&`b_req`=1 outside reset.
  - Adds output `a_stall_cnt` [15:0]: increments each cycle `a_stall`=1.
  - Both clear on `rst`.
- When undefined: neither port nor counter exists, and arbitration behaviour is identical.

Test Plan:
- **A only:** `a_req`=1, `a_we`=1, addr 5, wdata 0xDEADBEEF, then a read of addr 5 → `a_ready`=1 both cycles, `a_stall`=0, `a_rdata`=0xDEADBEEF on the read cycle.
- **Contention:** `a_req`=`b_req`=1 held for 6 cycles, `STARVE_LIM`=4 → A granted cycles 0-3, B granted cycle 4 (`a_stall`=1 only in cycle 4), A granted cycle 5.
- **Lock:** B asserts `b_lock` with writes to addrs 1, 2, 3 while `a_req`=1 → `b_ready`=1 for 3 cycles, `a_stall`=1 throughout. `b_lock`=0 → A granted on the following cycle.
- **Reset mid-lock:** `rst`=1 during `LOCK_B` → all ready signals 0 and `dm_cs`=0 that cycle. After `rst`=0 with `a_req`=1, `b_lock`=0 → A granted immediately.
- **Idle:** no requests → `dm_cs`=`dm_r`=`dm_w`=0, `dm_addr`=0, `starve_cnt` stays 0.
- **Stats** (`DMEM_ARB_STATS_EN` defined): the contention scenario above → `conflict_cnt`=6, `a_stall_cnt`=1.
